alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle MIPS ALU.
- Keeps the combinational ADD/SUB/AND/OR/SLT datapath with a corrected Zero flag, and adds signed SLT.
- Adds an iterative multiply/divide engine with architectural HI/LO registers and a start/busy/done handshake.
- Sits in the MIPS execute stage; the controller stalls on busy for MULT/DIV and reads HI/LO via MFHI/MFLO.

Parameters:
- WIDTH, 32, datapath width; must be even and ≥ 4.
- CTRL_W, 4, ALUControl width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ALUControl  input  CTRL_W  operation select; see Behaviour.
- SrcA  input  WIDTH  operand A / dividend / multiplicand.
- SrcB  input  WIDTH  operand B / divisor / multiplier.
- start  input  1  launches the multi-cycle op encoded on ALUControl.
- ALUResult  output  WIDTH  combinational result.
- Zero  output  1  ALUResult == 0, every op.
- busy  output  1  multi-cycle engine active.
- done  output  1  one-cycle pulse: HI/LO updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, named reset.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLTU; 0101 SLT (signed).
  - 1000 MULT; 1001 MULTU; 1010 DIV; 1011 DIVU.
  - 1100 MFHI (ALUResult = hi); 1101 MFLO (ALUResult = lo).
  - 1110 MTHI; 1111 MTLO.
  - All other codes: ALUResult = 0.
- Combinational ops:
  - ALUResult is valid in the same cycle and wraps modulo 2^WIDTH.
  - SLT/SLTU produce 1 or 0 zero-extended.
  - Zero = ~|ALUResult for every code, including default; no latch is inferred.
  - ALUResult is 0 for MULT..DIVU and for MTHI/MTLO.
- MTHI/MTLO: when start=1 and the engine is idle, hi (or lo) <= SrcA at the clock edge; single cycle, no done pulse.
- FSM: IDLE -> CALC -> FIX -> IDLE.
  - IDLE: on start=1 with opcode MULT..DIVU at edge E0:
    - latch |SrcA| and |SrcB| for signed ops (raw values for unsigned), the result signs and the op;
    - counter <= WIDTH-1; go to CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for WIDTH cycles (edges E1..E_WIDTH); goes to FIX when counter hits 0.
  - FIX: at edge E_WIDTH+1:
    - apply sign correction and write hi/lo;
    - done <= 1 for exactly one cycle; return to IDLE.
- busy = (state != IDLE); a combinational decode of the state register.
- Total latency: start edge to done visible is WIDTH+1 edges (33 for WIDTH=32).
- start while busy is ignored: no restart, and operands are not re-latched.
- start with a non-multi-cycle opcode in IDLE is ignored, except MTHI/MTLO.
- Operands are captured at E0; later SrcA/SrcB changes do not affect the result.
- Multiply: {hi,lo} = full 2·WIDTH-bit product. MULT is signed two's complement; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (either signedness): lo = all ones, hi = SrcA. Normal latency; no exception.
  - DIV of MIN_INT by −1: lo = MIN_INT, hi = 0.
- While the engine runs, combinational ops and MFHI/MFLO remain usable. MFHI/MFLO return the old hi/lo until the done edge.
- Reset (any time, including mid-operation): state = IDLE, counter = 0, hi = 0, lo = 0, done = 0, busy = 0. The in-flight op is discarded.
- Within one edge, an FSM write to hi/lo takes priority over MTHI/MTLO. This cannot coincide in practice, since MT* is only accepted in IDLE.

Decomposition:
- Package alu_pkg: typedef alu_op_e (CTRL_W-bit enum of all opcodes), typedef md_state_e {IDLE, CALC, FIX}, and helper function is_muldiv(op).
- Sub-module muldiv_seq: FSM, counter, shift registers and sign fixup, exposing start/busy/done/hi/lo.
- Top alu_muldiv: the combinational ALU, the ALUResult/Zero muxes, and MTHI/MTLO gating.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> 0x80000000, Zero=0; SUB 5−5 -> 0, Zero=1; SLT −1 < 1 -> 1; SLTU 0xFFFFFFFF < 1 -> 0.
- MULT −3 × 7 (start pulse) -> busy for 33 cycles, done pulse at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0xFFFFFFFF² -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7 / 2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000 / −1 -> lo=0x80000000, hi=0.
- Second start pulse at cycle 10 of a DIV, with changed SrcA/SrcB -> ignored, original result delivered, exactly one done pulse; MFLO during busy -> previous lo.
- Assert reset at cycle 15 of a MULT -> busy=0, hi=lo=0 immediately (asynchronous); no done pulse; a new MULT after reset completes normally.
- MTHI 0xDEADBEEF then MFHI -> ALUResult 0xDEADBEEF, Zero=0; MTLO 0 then MFLO -> Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state types for the ALU with iterative multiply/divide engine.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLT   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLTU  = 4'b0111,
    OP_MULT  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIV   = 4'b1010,
    OP_DIVU  = 4'b1011,
    OP_MFHI  = 4'b1100,
    OP_MFLO  = 4'b1101,
    OP_MTHI  = 4'b1110,
    OP_MTLO  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input alu_op_e op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine: magnitude shift-add / restoring divide,
// sign fix-up in a final cycle, and the architectural HI/LO registers.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CW = $clog2(WIDTH);

  md_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_signed = ~i_op[0];
  assign w_abs_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_abs_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // r_q doubles as multiplier (shifted out LSB-first) and dividend/quotient
  assign w_add   = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_b};

  assign w_prod     = {r_rem, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  // Divide by zero yields an all-ones quotient; the remainder path already holds |SrcA|
  assign w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -r_q : r_q);
  assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && is_muldiv(alu_op_e'(i_op))) begin
            r_rem   <= '0;
            r_q     <= w_abs_a;
            r_b     <= w_abs_b;
            r_div   <= i_op[1];
            r_neg_q <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= w_signed & i_a[WIDTH-1];
            r_div0  <= (i_b == '0);
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_div) begin
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_rem <= w_add[WIDTH:1];
            r_q   <= {w_add[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The engine's result write wins over MTHI/MTLO on the same edge
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      r_hi <= r_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
      r_lo <= r_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
    end else if (i_mthi) begin
      r_hi <= i_a;
    end else if (i_mtlo) begin
      r_lo <= i_a;
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational ADD/SUB/logic/compare datapath, HI/LO moves,
// and the multi-cycle multiply/divide engine.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]  SrcA,
  input  logic [WIDTH-1:0]  SrcB,
  input  logic              start,
  output logic [WIDTH-1:0]  ALUResult,
  output logic              Zero,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);
  alu_op_e          w_op;
  logic             w_busy;
  logic             w_mthi;
  logic             w_mtlo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_result;

  assign w_op   = alu_op_e'(ALUControl[3:0]);
  // HI/LO moves are only accepted while the engine is idle
  assign w_mthi = start && !w_busy && (w_op == OP_MTHI);
  assign w_mtlo = start && !w_busy && (w_op == OP_MTLO);

  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk),
    .i_rst  (reset),
    .i_start(start),
    .i_op   (ALUControl[3:0]),
    .i_a    (SrcA),
    .i_b    (SrcB),
    .i_mthi (w_mthi),
    .i_mtlo (w_mtlo),
    .o_busy (w_busy),
    .o_done (done),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  always_comb begin
    w_result = '0;
    case (w_op)
      OP_AND:  w_result = SrcA & SrcB;
      OP_OR:   w_result = SrcA | SrcB;
      OP_ADD:  w_result = SrcA + SrcB;
      OP_SUB:  w_result = SrcA - SrcB;
      OP_SLTU: w_result = WIDTH'(SrcA < SrcB);
      OP_SLT:  w_result = WIDTH'($signed(SrcA) < $signed(SrcB));
      OP_MFHI: w_result = w_hi;
      OP_MFLO: w_result = w_lo;
      default: w_result = '0;
    endcase
  end

  assign ALUResult = w_result;
  assign Zero      = ~|w_result;
  assign busy      = w_busy;
  assign hi        = w_hi;
  assign lo        = w_lo;

endmodule
